// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the RV32M multiply/divide sequencer.
// Holds ALU select codes, op-class and funct3 constants, FSM states and operand-sign helpers.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    localparam logic [2:0] OP_R      = 3'b000;
    localparam logic [2:0] OP_I      = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_LUI    = 3'b101;
    localparam logic [2:0] OP_AUIPC  = 3'b110;
    localparam logic [2:0] OP_JUMP   = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Iteration counter must reach XLEN-1; never narrower than 6 bits.
    function automatic int cnt_width(input int xlen);
        return ($clog2(xlen) + 1 > 6) ? $clog2(xlen) + 1 : 6;
    endfunction

    function automatic logic op_a_signed(input logic [2:0] f3);
        return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative datapath shared by multiply and divide: one shift-add or restoring shift-subtract per step.
// acc holds {hi, lo}: product accumulator for MUL, {remainder, quotient/dividend} for DIV.
module md_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_nxt_o,
    output logic              last_o
);

    localparam int CNT_W = cnt_width(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift[XLEN-1:0] - opb_q;
        if (div_i) begin
            acc_nxt_o = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_nxt_o = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_i};
            opb_d = b_i;
            cnt_d = '0;
        end else if (step_i) begin
            acc_d = acc_nxt_o;
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign last_o = (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder with an iterative RV32M multiply/divide sequencer (busy/valid handshake).
//   state   | meaning
//   IDLE    | decode only; accept an M op (busy raised combinationally)
//   MUL     | XLEN shift-add steps on operand magnitudes
//   DIV     | XLEN restoring shift-subtract steps on operand magnitudes
//   DONE    | one-cycle o_md_valid pulse, result register holds
module alu_control_md
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_flush,
    input  logic [2:0]      i_alu_op,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_funct7,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic [3:0]      o_alu_control,
    output logic            o_md_busy,
    output logic            o_md_valid,
    output logic [XLEN-1:0] o_md_result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q, state_d;
    logic [2:0]      fn_q, fn_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_m_enc, m_go;
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, div_ovf, is_div_op, special;
    logic [XLEN-1:0] spec_val;

    logic            core_load, core_step, core_last;
    logic [2*XLEN-1:0] acc_nxt, prod_s;
    logic [XLEN-1:0] quot_s, rem_s, fin_val;
    logic            busy, valid;

    assign is_m_enc = (i_alu_op == OP_R) && (i_funct7 == FUNCT7_MULDIV);
    assign m_go     = i_valid && is_m_enc && !i_flush && !i_rst;

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            OP_R: begin
                if (i_funct7 != FUNCT7_MULDIV) begin
                    case ({i_funct7[5], i_funct3})
                        4'b0000: o_alu_control = ALU_ADD;
                        4'b1000: o_alu_control = ALU_SUB;
                        4'b0001: o_alu_control = ALU_SLL;
                        4'b0010: o_alu_control = ALU_SLT;
                        4'b0011: o_alu_control = ALU_SLTU;
                        4'b0100: o_alu_control = ALU_XOR;
                        4'b0101: o_alu_control = ALU_SRL;
                        4'b1101: o_alu_control = ALU_SRA;
                        4'b0110: o_alu_control = ALU_OR;
                        4'b0111: o_alu_control = ALU_AND;
                        default: o_alu_control = ALU_ADD;
                    endcase
                end
            end
            OP_I: begin
                case (i_funct3)
                    3'b000:  o_alu_control = ALU_ADD;
                    3'b001:  o_alu_control = ALU_SLL;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b011:  o_alu_control = ALU_SLTU;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b101:  o_alu_control = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alu_control = ALU_OR;
                    default: o_alu_control = ALU_AND;
                endcase
            end
            OP_LUI: o_alu_control = ALU_LUI;
            OP_BRANCH: begin
                case (i_funct3)
                    3'b000, 3'b001: o_alu_control = ALU_SUB;
                    3'b100, 3'b101: o_alu_control = ALU_SLT;
                    3'b110, 3'b111: o_alu_control = ALU_SLTU;
                    default:        o_alu_control = ALU_ADD;
                endcase
            end
            OP_LOAD, OP_STORE, OP_AUIPC, OP_JUMP: o_alu_control = ALU_ADD;
            default: o_alu_control = ALU_ADD;
        endcase
    end

    // Operand conditioning at acceptance: magnitudes go to the core, signs are kept here.
    always_comb begin
        a_sgn     = op_a_signed(i_funct3) && i_op_a[XLEN-1];
        b_sgn     = op_b_signed(i_funct3) && i_op_b[XLEN-1];
        a_mag     = a_sgn ? -i_op_a : i_op_a;
        b_mag     = b_sgn ? -i_op_b : i_op_b;
        is_div_op = i_funct3[2];
        b_zero    = (i_op_b == '0);
        div_ovf   = (i_funct3 == F3_DIV || i_funct3 == F3_REM) &&
                    (i_op_a == MOST_NEG) && (i_op_b == '1);
        special   = is_div_op && (b_zero || div_ovf);
        if (b_zero) begin
            spec_val = i_funct3[1] ? i_op_a : '1;
        end else begin
            spec_val = i_funct3[1] ? '0 : i_op_a;
        end
    end

    md_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .load_i    (core_load),
        .step_i    (core_step),
        .div_i     (state_q == ST_DIV),
        .a_i       (a_mag),
        .b_i       (b_mag),
        .acc_nxt_o (acc_nxt),
        .last_o    (core_last)
    );

    // Final value is formed from the core's last-step result so it lands in result_q on entry to DONE.
    always_comb begin
        prod_s = neg_q_q ? -acc_nxt : acc_nxt;
        quot_s = neg_q_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_s  = neg_r_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        if (spec_q) begin
            fin_val = spec_res_q;
        end else if (state_q == ST_DIV) begin
            fin_val = fn_q[1] ? rem_s : quot_s;
        end else begin
            fin_val = (fn_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d    = state_q;
        fn_d       = fn_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        core_load  = 1'b0;
        core_step  = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m_go) begin
                    busy       = 1'b1;
                    core_load  = 1'b1;
                    fn_d       = i_funct3;
                    neg_q_d    = a_sgn ^ b_sgn;
                    neg_r_d    = a_sgn;
                    spec_d     = special;
                    spec_res_d = spec_val;
                    if (EARLY_OUT && special) begin
                        state_d  = ST_DONE;
                        result_d = spec_val;
                    end else begin
                        state_d = is_div_op ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    busy      = 1'b1;
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d  = ST_DONE;
                        result_d = fin_val;
                    end
                end
            end
            ST_DONE: begin
                valid   = !i_flush;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            fn_q       <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            fn_q       <= fn_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
        end
    end

    assign o_md_busy   = busy && !i_rst;
    assign o_md_valid  = valid && !i_rst;
    assign o_md_result = result_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: decode vector table, M-op vector table with a result scoreboard,
// and hand sequences for flush, reset mid-operation and back-to-back acceptance.
module tb_alu_control_md;

    localparam int XLEN = 32;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_flush;
    logic [2:0]  i_alu_op, i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_op_a, i_op_b;
    logic [3:0]  o_alu_control;
    logic        o_md_busy, o_md_valid;
    logic [31:0] o_md_result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       v;
        logic [3:0] exp;
    } dec_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } md_vec_t;

    dec_vec_t    dec_tab[$];
    md_vec_t     md_tab[$];
    logic [31:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    alu_control_md #(
        .XLEN      (XLEN),
        .EARLY_OUT (1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_flush       (i_flush),
        .i_alu_op      (i_alu_op),
        .i_funct3      (i_funct3),
        .i_funct7      (i_funct7),
        .i_op_a        (i_op_a),
        .i_op_b        (i_op_b),
        .o_alu_control (o_alu_control),
        .o_md_busy     (o_md_busy),
        .o_md_valid    (o_md_valid),
        .o_md_result   (o_md_result)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic dec_vec_t mkd(input logic [2:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic v, input logic [3:0] e);
        dec_vec_t d;
        d.op = op; d.f3 = f3; d.f7 = f7; d.v = v; d.exp = e;
        return d;
    endfunction

    function automatic md_vec_t mkm(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] e, input int lat);
        md_vec_t m;
        m.f3 = f3; m.a = a; m.b = b; m.exp = e; m.lat = lat;
        return m;
    endfunction

    // Reference for non-special operands, built on native 64-bit multiply and SV division.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
        bx = (f3 == 3'b010 || f3 == 3'b011) ? {32'b0, b} : {{32{b[31]}}, b};
        p  = ax * bx;
        case (f3)
            3'b000:                 return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100:                 return 32'($signed(a) / $signed(b));
            3'b101:                 return a / b;
            3'b110:                 return 32'($signed(a) % $signed(b));
            default:                return a % b;
        endcase
    endfunction

    task automatic wait_valid(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge i_clk);
            lat++;
            if (o_md_valid) got = 1'b1;
            else check("busy_during_op", {31'b0, o_md_busy}, 32'd1);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout got no pulse expected one within 100 cycles");
        end
    endtask

    task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        i_valid  = 1'b1;
        i_alu_op = 3'b000;
        i_funct7 = 7'h01;
        i_funct3 = f3;
        i_op_a   = a;
        i_op_b   = b;
    endtask

    task automatic run_md(input md_vec_t v);
        int          lat;
        bit          got;
        logic [31:0] e;
        @(posedge i_clk); #1;
        drive_m(v.f3, v.a, v.b);
        @(negedge i_clk);
        check("accept_busy", {31'b0, o_md_busy}, 32'd1);
        check("m_alu_control", {28'b0, o_alu_control}, 32'd0);
        exp_q.push_back(v.exp);
        @(posedge i_clk); #1;
        i_op_a = $urandom;
        i_op_b = $urandom;
        wait_valid(lat, got);
        e = exp_q.pop_front();
        if (got) begin
            check($sformatf("latency f3=%0d a=%h b=%h", v.f3, v.a, v.b), lat, v.lat);
            check("busy_at_valid", {31'b0, o_md_busy}, 32'd0);
            check($sformatf("result f3=%0d a=%h b=%h", v.f3, v.a, v.b), o_md_result, e);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        check("valid_one_cycle", {31'b0, o_md_valid}, 32'd0);
        check("result_hold", o_md_result, e);
    endtask

    initial begin
        int          lat;
        bit          got;
        int          seen;
        logic [31:0] e, ra, rb;

        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        i_alu_op = '0; i_funct3 = '0; i_funct7 = '0; i_op_a = '0; i_op_b = '0;

        dec_tab.push_back(mkd(3'b000, 3'b000, 7'h00, 1'b1, 4'b0000));
        dec_tab.push_back(mkd(3'b000, 3'b000, 7'h20, 1'b1, 4'b0001));
        dec_tab.push_back(mkd(3'b000, 3'b001, 7'h00, 1'b1, 4'b0010));
        dec_tab.push_back(mkd(3'b000, 3'b010, 7'h00, 1'b1, 4'b0011));
        dec_tab.push_back(mkd(3'b000, 3'b011, 7'h00, 1'b1, 4'b0100));
        dec_tab.push_back(mkd(3'b000, 3'b100, 7'h00, 1'b1, 4'b0101));
        dec_tab.push_back(mkd(3'b000, 3'b101, 7'h00, 1'b1, 4'b0110));
        dec_tab.push_back(mkd(3'b000, 3'b101, 7'h20, 1'b1, 4'b0111));
        dec_tab.push_back(mkd(3'b000, 3'b110, 7'h00, 1'b1, 4'b1000));
        dec_tab.push_back(mkd(3'b000, 3'b111, 7'h00, 1'b1, 4'b1001));
        dec_tab.push_back(mkd(3'b000, 3'b001, 7'h20, 1'b1, 4'b0000));
        dec_tab.push_back(mkd(3'b000, 3'b110, 7'h01, 1'b0, 4'b0000));
        dec_tab.push_back(mkd(3'b001, 3'b000, 7'h20, 1'b1, 4'b0000));
        dec_tab.push_back(mkd(3'b001, 3'b101, 7'h20, 1'b1, 4'b0111));
        dec_tab.push_back(mkd(3'b001, 3'b101, 7'h00, 1'b1, 4'b0110));
        dec_tab.push_back(mkd(3'b001, 3'b110, 7'h00, 1'b1, 4'b1000));
        dec_tab.push_back(mkd(3'b010, 3'b010, 7'h00, 1'b1, 4'b0000));
        dec_tab.push_back(mkd(3'b011, 3'b010, 7'h00, 1'b1, 4'b0000));
        dec_tab.push_back(mkd(3'b100, 3'b000, 7'h00, 1'b1, 4'b0001));
        dec_tab.push_back(mkd(3'b100, 3'b101, 7'h00, 1'b1, 4'b0011));
        dec_tab.push_back(mkd(3'b100, 3'b110, 7'h00, 1'b1, 4'b0100));
        dec_tab.push_back(mkd(3'b100, 3'b010, 7'h00, 1'b1, 4'b0000));
        dec_tab.push_back(mkd(3'b101, 3'b000, 7'h00, 1'b1, 4'b1010));
        dec_tab.push_back(mkd(3'b110, 3'b000, 7'h00, 1'b1, 4'b0000));
        dec_tab.push_back(mkd(3'b111, 3'b000, 7'h00, 1'b1, 4'b0000));

        md_tab.push_back(mkm(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33));
        md_tab.push_back(mkm(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33));
        md_tab.push_back(mkm(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33));
        md_tab.push_back(mkm(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33));
        md_tab.push_back(mkm(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33));
        md_tab.push_back(mkm(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33));
        md_tab.push_back(mkm(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33));
        md_tab.push_back(mkm(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33));
        md_tab.push_back(mkm(3'b101, 32'd100,       32'd7,         32'd14,        33));
        md_tab.push_back(mkm(3'b111, 32'd100,       32'd7,         32'd2,         33));
        md_tab.push_back(mkm(3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33));
        md_tab.push_back(mkm(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1));
        md_tab.push_back(mkm(3'b111, 32'd5,         32'd0,         32'd5,         1));
        md_tab.push_back(mkm(3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1));
        md_tab.push_back(mkm(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1));
        md_tab.push_back(mkm(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1));
        for (int r = 0; r < 2; r++) begin
            for (int f = 0; f < 8; f++) begin
                ra = $urandom;
                rb = $urandom;
                rb = {rb[31:2], 2'b01};
                md_tab.push_back(mkm(3'(f), ra, rb, ref_md(3'(f), ra, rb), 33));
            end
        end

        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_busy",   {31'b0, o_md_busy},  32'd0);
        check("reset_valid",  {31'b0, o_md_valid}, 32'd0);
        check("reset_result", o_md_result,         32'd0);

        foreach (dec_tab[i]) begin
            @(posedge i_clk); #1;
            i_alu_op = dec_tab[i].op;
            i_funct3 = dec_tab[i].f3;
            i_funct7 = dec_tab[i].f7;
            i_valid  = dec_tab[i].v;
            @(negedge i_clk);
            check($sformatf("decode op=%b f7=%h f3=%b", dec_tab[i].op, dec_tab[i].f7, dec_tab[i].f3),
                  {28'b0, o_alu_control}, {28'b0, dec_tab[i].exp});
            check("decode_busy", {31'b0, o_md_busy}, 32'd0);
        end
        @(posedge i_clk); #1 i_valid = 1'b0;

        foreach (md_tab[i]) run_md(md_tab[i]);

        // Flush ten cycles into a divide: no pulse, then a clean multiply.
        @(posedge i_clk); #1;
        drive_m(3'b100, 32'd1000, 32'd3);
        @(negedge i_clk);
        check("flush_accept", {31'b0, o_md_busy}, 32'd1);
        repeat (10) @(posedge i_clk);
        #1 i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        check("flush_busy",  {31'b0, o_md_busy},  32'd0);
        check("flush_valid", {31'b0, o_md_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_md_valid) seen++;
        end
        check("flush_no_valid", seen, 0);
        run_md(mkm(3'b000, 32'd3, 32'd4, 32'd12, 33));

        // Back-to-back with i_valid held: second op accepted in IDLE after DONE.
        @(posedge i_clk); #1;
        drive_m(3'b000, 32'd5, 32'd6);
        @(negedge i_clk);
        check("b2b_first_accept", {31'b0, o_md_busy}, 32'd1);
        exp_q.push_back(32'd30);
        wait_valid(lat, got);
        e = exp_q.pop_front();
        if (got) begin
            check("b2b_first_latency", lat, 33);
            check("b2b_first_result", o_md_result, e);
        end
        i_op_a = 32'd7;
        i_op_b = 32'd8;
        @(negedge i_clk);
        check("b2b_second_accept", {31'b0, o_md_busy},  32'd1);
        check("b2b_gap_valid",     {31'b0, o_md_valid}, 32'd0);
        exp_q.push_back(32'd56);
        wait_valid(lat, got);
        e = exp_q.pop_front();
        if (got) begin
            check("b2b_second_latency", lat, 33);
            check("b2b_second_result", o_md_result, e);
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        check("b2b_valid_drop", {31'b0, o_md_valid}, 32'd0);

        // Reset in the middle of a multiply clears everything and never pulses valid.
        @(posedge i_clk); #1;
        drive_m(3'b000, 32'd9, 32'd9);
        @(negedge i_clk);
        check("rst_accept", {31'b0, o_md_busy}, 32'd1);
        repeat (10) @(posedge i_clk);
        #1;
        i_rst = 1'b1; i_valid = 1'b0; i_alu_op = '0; i_funct3 = '0; i_funct7 = '0;
        i_op_a = '0; i_op_b = '0;
        @(negedge i_clk);
        check("rst_busy_during", {31'b0, o_md_busy}, 32'd0);
        @(posedge i_clk); #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_busy",        {31'b0, o_md_busy},      32'd0);
        check("rst_valid",       {31'b0, o_md_valid},     32'd0);
        check("rst_result",      o_md_result,             32'd0);
        check("rst_alu_control", {28'b0, o_alu_control},  32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_md_valid) seen++;
        end
        check("rst_no_valid", seen, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Produces the same 4-bit ALU control codes for RV32I ops and adds an RV32M multiply/divide sequencer: iterative radix-2 shift-add multiplier and restoring divider, with a busy/valid handshake toward the pipeline.
- Sits in the execute stage beside the ALU. The writeback mux selects o_md_result when o_md_valid is high.

Parameters:
- XLEN, 32, operand/result width (≥8, even).
- EARLY_OUT, 1, when 1, divide-by-zero and signed-overflow cases finish without iterating.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  instruction in execute is valid
- i_flush  input  1  abort any in-flight M operation
- i_alu_op  input  3  op class from main control (000 R, 001 I, 010 LOAD, 011 STORE, 100 BRANCH, 101 LUI, 110 AUIPC, 111 JUMP)
- i_funct3  input  3  instruction funct3
- i_funct7  input  7  instruction funct7
- i_op_a  input  XLEN  rs1 value
- i_op_b  input  XLEN  rs2 value
- o_alu_control  output  4  ALU operation select
- o_md_busy  output  1  stall request; the pipeline holds execute inputs stable while high
- o_md_valid  output  1  one-cycle pulse: o_md_result is valid
- o_md_result  output  XLEN  M-extension result

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high. i_rst wins over all other inputs.
- Reset values: FSM=IDLE, o_md_busy=0, o_md_valid=0, o_md_result=0, all datapath registers 0.
- Decode (combinational, unchanged semantics):
  - R: {funct7[5],funct3} → ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
  - I: same mapping, except funct3=101 uses funct7[5] to select SRA.
  - LOAD/STORE/AUIPC/JUMP: 0000.
  - LUI: 1010.
  - BRANCH: 000/001 → SUB, 100/101 → SLT, 110/111 → SLTU.
  - Anything undefined: 0000.
- M op detect: i_valid & i_alu_op==000 & i_funct7==0000001. funct3 selects: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111. During an M op, o_alu_control=0000 (ALU result is ignored).
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On M op detect, o_md_busy=1 combinationally in the same cycle.
  - Latch |a|, |b| and the result sign per op:
    - MULH: both operands signed.
    - MULHSU: a signed, b unsigned.
    - MULHU/DIVU/REMU: unsigned.
    - DIV/REM: signed.
  - Clear the 6-bit-or-wider iteration counter. Go to MUL or DIV.
- MUL:
  - 2*XLEN accumulator, one multiplier bit per cycle, exactly XLEN cycles.
  - Then negate if the sign flag is set. Select the low half (MUL) or high half (MULH*). Go to DONE.
- DIV:
  - Restoring divider, one quotient bit per cycle, exactly XLEN cycles.
  - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
  - Select quotient (DIV/DIVU) or remainder (REM/REMU). Go to DONE.
- Special cases (when EARLY_OUT=1, decided in IDLE and go straight to DONE next cycle; when EARLY_OUT=0, iterate but force the same results):
  - b==0: quotient = all ones, remainder = a.
  - Signed a==−2^(XLEN−1) with b==−1: quotient = a, remainder = 0.
- DONE:
  - o_md_valid=1 and o_md_busy=0 for exactly one cycle; o_md_result holds the value. Return to IDLE.
  - The pipeline advances this cycle. A new M op is not accepted in DONE; acceptance resumes in IDLE next cycle.
  - o_md_result holds its value until the next DONE.
- Latency, acceptance cycle to the o_md_valid cycle: XLEN+1 cycles for normal ops (33 at XLEN=32), 1 cycle for early-out cases.
- o_md_busy is high from the acceptance cycle through the last MUL/DIV cycle.
- i_flush in any state other than IDLE: go to IDLE next cycle, o_md_busy=0, no o_md_valid pulse.
- i_flush in IDLE suppresses acceptance.
- i_rst mid-operation: same as reset, and no o_md_valid pulse.
- Operand inputs are sampled only at acceptance. Later changes are ignored.

Decomposition:
- Shared package alu_pkg:
  - ALU control code constants (ADD..LUI).
  - ALU_OP class constants.
  - M funct3 constants.
  - FUNCT7_MULDIV=7'b0000001.
  - FSM state enum.
- Decode stays in this module.
- One sub-module: md_iter_core (XLEN param). It holds the accumulator/remainder/counter datapath, performing one shift-add or shift-subtract step per enable. The FSM and sign/special-case handling stay in alu_control_md.

Test Plan:
- RV32I decode sweep: alu_op=000 with {f7[5],f3}=1101 → 0111; BRANCH f3=110 → 0100; alu_op=101 → 1010; o_md_busy stays 0.
- MUL a=7, b=−3 → o_md_valid exactly 33 cycles after acceptance, result 0xFFFFFFEB. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=−1, b=2 → 0xFFFFFFFF.
- DIV a=−7, b=2 → quotient 0xFFFFFFFD. REM a=−7, b=2 → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU a=100, b=7 → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each valid 1 cycle after acceptance (EARLY_OUT=1). DIV 0x80000000/−1 → 0x80000000. REM 0x80000000/−1 → 0.
- Abort: i_flush at cycle 10 of a DIV → no o_md_valid, o_md_busy=0 next cycle, and a following MUL 3*4 → 12. Repeat with i_rst mid-MUL → all outputs 0.
- Back-to-back: two MUL ops with i_valid held → second accepted the cycle after DONE, two distinct o_md_valid pulses.
